gvt_controller: RTL and testbench

GVT_CONTROLLER -- requirements
Module: gvt_controller

---
 rtl/chronos_pkg.sv | 26 ++
 rtl/vt_min_reg.sv | 42 ++++
 rtl/gvt_controller.sv | 190 +++++++++++++++++++
 tb/tb_gvt_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// chronos_pkg -- shared definitions for the GVT (global virtual time) block.
//   CHR_*          : default geometry picked up by gvt_controller parameters
//   vt_t           : packed virtual-time value {ts, tb}; ordering is the
//                    unsigned order of the packed vector (ts first, then tb)
//   gvt_state_e    : GVT round FSM states
package chronos_pkg;

    localparam int CHR_N_TILES        = 4;
    localparam int CHR_TS_WIDTH       = 32;
    localparam int CHR_TB_WIDTH       = 32;
    localparam int CHR_LOG_GVT_PERIOD = 5;

    typedef struct packed {
        logic [CHR_TS_WIDTH-1:0] ts;
        logic [CHR_TB_WIDTH-1:0] tb;
    } vt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COLLECT,
        ST_REDUCE,
        ST_PUBLISH
    } gvt_state_e;

endpackage

// File: rtl/vt_min_reg.sv
// vt_min_reg -- registered two-input lexicographic compare-and-hold.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : take vt_i unconditionally (first element of a reduction)
//   cmp_i     : replace held value when vt_i is strictly smaller
//   vt_i      : candidate {ts,tb} value
//   min_o     : currently held minimum
// Strict less-than keeps the earlier element on ties.
module vt_min_reg
    import chronos_pkg::*;
#(
    parameter int W = $bits(vt_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         cmp_i,
    input  logic [W-1:0] vt_i,
    output logic [W-1:0] min_o
);

    logic [W-1:0] min_q, min_d;

    always_comb begin
        min_d = min_q;
        if (load_i) begin
            min_d = vt_i;
        end else if (cmp_i && (vt_i < min_q)) begin
            min_d = vt_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
        end else begin
            min_q <= min_d;
        end
    end

    assign min_o = min_q;

endmodule

// File: rtl/gvt_controller.sv
// gvt_controller -- periodic GVT computation over N_TILES tiles.
// Every 2^LOG_GVT_PERIOD enabled idle cycles a round starts: all tiles get a
// one-cycle lvt_req, responses are latched until every tile has answered,
// then the minimum {ts,tb} is reduced one tile per cycle and published if it
// does not move GVT backwards.
//   clk, rst          : clock, asynchronous active-high reset
//   gvt_en            : enables starting new rounds (a running round always completes)
//   lvt_req           : request pulse to all tiles
//   lvt_valid/ts/tb   : per-tile LVT responses
//   gvt_ts/gvt_tb     : current GVT (shows the new value during the gvt_valid pulse)
//   gvt_valid         : one-cycle pulse on GVT update
//   gvt_regress_err   : sticky, set when a round's minimum is below GVT
// Optional macro GVT_STATS_EN adds stat_rounds / stat_max_collect outputs.
module gvt_controller
    import chronos_pkg::*;
#(
    parameter int N_TILES        = CHR_N_TILES,
    parameter int TS_WIDTH       = CHR_TS_WIDTH,
    parameter int TB_WIDTH       = CHR_TB_WIDTH,
    parameter int LOG_GVT_PERIOD = CHR_LOG_GVT_PERIOD
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gvt_en,
    output logic [N_TILES-1:0]                 lvt_req,
    input  logic [N_TILES-1:0]                 lvt_valid,
    input  logic [N_TILES-1:0][TS_WIDTH-1:0]   lvt_ts,
    input  logic [N_TILES-1:0][TB_WIDTH-1:0]   lvt_tb,
    output logic [TS_WIDTH-1:0]                gvt_ts,
    output logic [TB_WIDTH-1:0]                gvt_tb,
    output logic                               gvt_valid,
    output logic                               gvt_regress_err
`ifdef GVT_STATS_EN
    ,
    output logic [31:0]                        stat_rounds,
    output logic [15:0]                        stat_max_collect
`endif
);

    localparam int VT_W  = TS_WIDTH + TB_WIDTH;
    localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int CNT_W = (LOG_GVT_PERIOD > 0) ? LOG_GVT_PERIOD : 1;
    localparam logic [CNT_W-1:0] CNT_TC   = (LOG_GVT_PERIOD > 0) ? {CNT_W{1'b1}} : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TILES - 1);

    gvt_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [N_TILES-1:0]               rcvd_q, rcvd_d;
    logic [N_TILES-1:0][VT_W-1:0]     lat_q, lat_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [VT_W-1:0]                  gvt_q, gvt_d;
    logic                             err_q, err_d;
    logic [VT_W-1:0]                  min_vt;
    logic                             pub_ok;

    // Reduction: tile 0 loads, later tiles compare against the held minimum.
    vt_min_reg #(.W(VT_W)) u_min (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_REDUCE && idx_q == '0),
        .cmp_i  (state_q == ST_REDUCE),
        .vt_i   (lat_q[idx_q]),
        .min_o  (min_vt)
    );

    assign pub_ok = (min_vt >= gvt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcvd_d  = rcvd_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        gvt_d   = gvt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!gvt_en) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_TC) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                // Fresh round: only strobes seen in this cycle count.
                rcvd_d  = lvt_valid;
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                rcvd_d = rcvd_q | lvt_valid;
                if (&rcvd_d) begin
                    idx_d   = '0;
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_PUBLISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PUBLISH: begin
                if (pub_ok) begin
                    gvt_d = min_vt;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q == ST_REQ || state_q == ST_COLLECT) begin
            for (int i = 0; i < N_TILES; i++) begin
                if (lvt_valid[i]) begin
                    lat_d[i] = {lvt_ts[i], lvt_tb[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcvd_q  <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            gvt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcvd_q  <= rcvd_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            gvt_q   <= gvt_d;
            err_q   <= err_d;
        end
    end

    assign lvt_req         = (state_q == ST_REQ) ? '1 : '0;
    assign gvt_valid       = (state_q == ST_PUBLISH) && pub_ok;
    // Bypass so the pulse cycle already carries the new GVT.
    assign {gvt_ts, gvt_tb} = gvt_valid ? min_vt : gvt_q;
    assign gvt_regress_err = err_q;

`ifdef GVT_STATS_EN
    logic [31:0] rounds_q, rounds_d;
    logic [15:0] coll_q, coll_d, cmax_q, cmax_d, coll_inc;

    always_comb begin
        rounds_d = rounds_q;
        coll_d   = coll_q;
        cmax_d   = cmax_q;
        coll_inc = (coll_q == 16'hFFFF) ? coll_q : coll_q + 16'd1;
        case (state_q)
            ST_REQ:     coll_d = '0;
            ST_COLLECT: begin
                coll_d = coll_inc;
                if (state_d == ST_REDUCE && coll_inc > cmax_q) begin
                    cmax_d = coll_inc;
                end
            end
            ST_PUBLISH: rounds_d = rounds_q + 32'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rounds_q <= '0;
            coll_q   <= '0;
            cmax_q   <= '0;
        end else begin
            rounds_q <= rounds_d;
            coll_q   <= coll_d;
            cmax_q   <= cmax_d;
        end
    end

    assign stat_rounds      = rounds_q;
    assign stat_max_collect = cmax_q;
`endif

endmodule

// File: tb/tb_gvt_controller.sv
module tb_gvt_controller;

  logic             clk, rst, gvt_en;
  logic [3:0]       lvt_req, lvt_valid;
  logic [3:0][31:0] lvt_ts, lvt_tb;
  logic [31:0]      gvt_ts, gvt_tb;
  logic             gvt_valid, gvt_regress_err;

  gvt_controller dut (
    .clk(clk), .rst(rst), .gvt_en(gvt_en),
    .lvt_req(lvt_req), .lvt_valid(lvt_valid), .lvt_ts(lvt_ts), .lvt_tb(lvt_tb),
    .gvt_ts(gvt_ts), .gvt_tb(gvt_tb), .gvt_valid(gvt_valid),
    .gvt_regress_err(gvt_regress_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: current GVT and sticky error
  logic [63:0] m_gvt;
  bit          m_err;

  // per-round stimulus description
  logic [31:0] r_ts[4], r_tb[4], r_gts[4], r_gtb[4];
  int          r_dly[4], r_dupc[4];
  bit          r_dup[4];
  bit          spur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int i, input logic [31:0] ts, input logic [31:0] tb, input int dly);
    r_ts[i] = ts; r_tb[i] = tb; r_dly[i] = dly; r_dup[i] = 0; r_dupc[i] = 0;
    r_gts[i] = '0; r_gtb[i] = '0;
  endtask

  task automatic rand_tiles();
    logic [31:0] base;
    base = m_gvt[63:32];
    for (int i = 0; i < 4; i++) begin
      r_ts[i]  = base + $urandom_range(0, 12) - 2;
      r_tb[i]  = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin r_ts[i] = '1; r_tb[i] = '1; end
      r_dly[i] = $urandom_range(0, 6);
      r_dup[i] = (r_dly[i] > 0) && ($urandom_range(0, 3) == 0);
      r_dupc[i] = r_dup[i] ? $urandom_range(0, r_dly[i] - 1) : 0;
      r_gts[i] = $urandom;
      r_gtb[i] = $urandom;
    end
  endtask

  // One GVT round: wait for the request (expected after exp_wait cycles),
  // drive responses, check the publish cycle and value. drop_at/rst_at are
  // round-relative cycles at which gvt_en is dropped / rst is asserted (-1: never).
  task automatic run_round(input int exp_wait, input int drop_at, input int rst_at);
    int waited, compl, first, cc, last;
    bit seen, ok;
    logic [63:0] val[4];
    logic [63:0] mn;
    waited = 0; seen = 0;
    while (!seen && waited < 300) begin
      @(negedge clk); waited++;
      if (lvt_req != 4'h0) seen = 1;
      else if (spur) begin
        lvt_valid = {3'b0, 1'($urandom_range(0, 1))};
        lvt_ts[0] = '0; lvt_tb[0] = '0;
      end
    end
    chk("req_wait", waited, exp_wait);
    if (!seen) return;

    // round completes once every tile has strobed; strobes up to cc count
    compl = 0;
    for (int i = 0; i < 4; i++) begin
      first = r_dup[i] ? r_dupc[i] : r_dly[i];
      if (first > compl) compl = first;
    end
    cc = (compl < 1) ? 1 : compl;
    for (int i = 0; i < 4; i++)
      val[i] = (r_dly[i] <= cc) ? {r_ts[i], r_tb[i]} : {r_gts[i], r_gtb[i]};
    mn = val[0];
    for (int i = 1; i < 4; i++) if (val[i] < mn) mn = val[i];
    ok   = (mn >= m_gvt);
    last = cc + 4 + 1;

    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);
      lvt_valid = '0;
      for (int i = 0; i < 4; i++) begin
        if (r_dup[i] && c == r_dupc[i]) begin
          lvt_valid[i] = 1'b1; lvt_ts[i] = r_gts[i]; lvt_tb[i] = r_gtb[i];
        end
        if (c == r_dly[i]) begin
          lvt_valid[i] = 1'b1; lvt_ts[i] = r_ts[i]; lvt_tb[i] = r_tb[i];
        end
      end
      if (c == drop_at) gvt_en = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_req",   lvt_req, 0);
        chk("rst_valid", gvt_valid, 0);
        chk("rst_gts",   gvt_ts, 0);
        chk("rst_gtb",   gvt_tb, 0);
        chk("rst_err",   gvt_regress_err, 0);
        m_gvt = '0; m_err = 0;
        lvt_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      chk("lvt_req", lvt_req, (c == 0) ? 4'hF : 4'h0);
      chk("gvt_valid", gvt_valid, (c == last) && ok);
      if (c == last) begin
        chk("gvt_ts_pub", gvt_ts, ok ? mn[63:32] : m_gvt[63:32]);
        chk("gvt_tb_pub", gvt_tb, ok ? mn[31:0]  : m_gvt[31:0]);
      end
    end
    if (ok) m_gvt = mn; else m_err = 1;
    @(negedge clk);
    lvt_valid = '0;
    chk("gvt_valid_post", gvt_valid, 0);
    chk("gvt_ts_post", gvt_ts, m_gvt[63:32]);
    chk("gvt_tb_post", gvt_tb, m_gvt[31:0]);
    chk("regress_err", gvt_regress_err, m_err);
  endtask

  initial begin
    rst = 1'b1; gvt_en = 1'b0; lvt_valid = '0; lvt_ts = '0; lvt_tb = '0;
    m_gvt = '0; m_err = 0; spur = 0;
    repeat (2) @(negedge clk);
    chk("reset_req",   lvt_req, 0);
    chk("reset_valid", gvt_valid, 0);
    chk("reset_gts",   gvt_ts, 0);
    chk("reset_gtb",   gvt_tb, 0);
    chk("reset_err",   gvt_regress_err, 0);
    rst = 1'b0; gvt_en = 1'b1;

    // basic minimum, replies one cycle after the request
    set_tile(0, 40, 0, 1); set_tile(1, 10, 0, 1); set_tile(2, 25, 0, 1); set_tile(3, 30, 0, 1);
    run_round(32, -1, -1);

    // tiebreaker ordering, then equal value republishes
    set_tile(0, 50, 7, 1); set_tile(1, 50, 3, 2); set_tile(2, 50, 3, 0); set_tile(3, 50, 9, 3);
    run_round(32, -1, -1);
    for (int i = 0; i < 4; i++) set_tile(i, 50, 3, 1);
    run_round(32, -1, -1);

    // regression: GVT 100, then a tile below it
    for (int i = 0; i < 4; i++) set_tile(i, 100, 0, 1);
    run_round(32, -1, -1);
    for (int i = 0; i < 4; i++) set_tile(i, 200, 0, 1);
    set_tile(2, 90, 0, 1);
    run_round(32, -1, -1);

    for (int k = 0; k < 8; k++) begin rand_tiles(); run_round(32, -1, -1); end

    // reset in the middle of REDUCE
    rand_tiles();
    for (int i = 0; i < 4; i++) r_dup[i] = 0;
    run_round(32, -1, 4 + 2);
    for (int i = 0; i < 4; i++) set_tile(i, 0, 0, 1);

    // late tile 3 with stray strobes on tile 0 while idle
    spur = 1;
    set_tile(0, 70, 1, 1); set_tile(1, 60, 2, 1); set_tile(2, 65, 0, 1); set_tile(3, 61, 0, 20);
    run_round(32, -1, -1);
    spur = 0;

    for (int k = 0; k < 15; k++) begin rand_tiles(); run_round(32, -1, -1); end

    // gvt_en dropped while collecting: round still publishes, then silence
    rand_tiles();
    run_round(32, 1, -1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      chk("no_req_disabled", lvt_req, 0);
    end
    gvt_en = 1'b1;
    rand_tiles();
    run_round(32, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
